// File: rtl/bus_arbiter.sv
// Two-master arbiter for the serial system bus.
// Grants one master at a time with round-robin tie breaking, drives the
// master-side mux select, and tracks a single outstanding split transaction
// so the split master is re-granted with top priority once the slave resumes.

module bus_arbiter (
    input  logic clk,
    input  logic rstn,
    input  logic breq1,
    input  logic breq2,
    input  logic split,
    input  logic split_done,
    output logic bgrant1,
    output logic bgrant2,
    output logic msel,
    output logic msplit1,
    output logic msplit2,
    output logic bus_busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT1 = 2'd1,
        GRANT2 = 2'd2
    } state_e;

    // Master index encoding used by last/split_own/grant_who: 0 = M1, 1 = M2.
    // This matches the msel encoding, so a grant copies the index straight
    // into msel.
    localparam logic MST1 = 1'b0;
    localparam logic MST2 = 1'b1;

    state_e state_q, state_d;
    logic   last_q, last_d;
    logic   split_pend_q, split_pend_d;
    logic   split_own_q, split_own_d;
    logic   bgrant1_q, bgrant1_d;
    logic   bgrant2_q, bgrant2_d;
    logic   msel_q, msel_d;
    logic   msplit1_q, msplit1_d;
    logic   msplit2_q, msplit2_d;

    logic   elig1_s;
    logic   elig2_s;
    logic   grant_req_s;
    logic   grant_who_s;

    // Eligibility: requesting and not parked as the pending split owner.
    always_comb begin
        elig1_s = breq1 & ~(split_pend_q & (split_own_q == MST1));
        elig2_s = breq2 & ~(split_pend_q & (split_own_q == MST2));
    end

    // Next-state and next-output logic for the arbitration FSM.
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        split_pend_d = split_pend_q;
        split_own_d  = split_own_q;
        bgrant1_d    = bgrant1_q;
        bgrant2_d    = bgrant2_q;
        msel_d       = msel_q;
        msplit1_d    = msplit1_q;
        msplit2_d    = msplit2_q;
        grant_req_s  = 1'b0;
        grant_who_s  = MST1;

        case (state_q)
            IDLE: begin
                if (split_pend_q && split_done) begin
                    // Resume (or abandonment cleanup) has top priority.
                    split_pend_d = 1'b0;
                    if (split_own_q == MST1) begin
                        msplit1_d   = 1'b0;
                        grant_req_s = breq1;
                        grant_who_s = MST1;
                    end else begin
                        msplit2_d   = 1'b0;
                        grant_req_s = breq2;
                        grant_who_s = MST2;
                    end
                end else if (elig1_s && !elig2_s) begin
                    grant_req_s = 1'b1;
                    grant_who_s = MST1;
                end else if (elig2_s && !elig1_s) begin
                    grant_req_s = 1'b1;
                    grant_who_s = MST2;
                end else if (elig1_s && elig2_s) begin
                    // Round-robin: the master that did not go last wins.
                    grant_req_s = 1'b1;
                    grant_who_s = ~last_q;
                end else begin
                    state_d = IDLE;
                end
            end

            GRANT1: begin
                if (!breq1) begin
                    state_d   = IDLE;
                    bgrant1_d = 1'b0;
                end else if (split && !split_pend_q) begin
                    state_d      = IDLE;
                    bgrant1_d    = 1'b0;
                    split_pend_d = 1'b1;
                    split_own_d  = MST1;
                    msplit1_d    = 1'b1;
                end else begin
                    // Either no split, or a second split while one is
                    // already outstanding: keep the grant.
                    state_d = GRANT1;
                end
            end

            GRANT2: begin
                if (!breq2) begin
                    state_d   = IDLE;
                    bgrant2_d = 1'b0;
                end else if (split && !split_pend_q) begin
                    state_d      = IDLE;
                    bgrant2_d    = 1'b0;
                    split_pend_d = 1'b1;
                    split_own_d  = MST2;
                    msplit2_d    = 1'b1;
                end else begin
                    state_d = GRANT2;
                end
            end

            default: begin
                // Unreachable encoding: drop any grant and re-arbitrate.
                state_d   = IDLE;
                bgrant1_d = 1'b0;
                bgrant2_d = 1'b0;
            end
        endcase

        if (grant_req_s) begin
            last_d = grant_who_s;
            msel_d = grant_who_s;
            if (grant_who_s == MST1) begin
                state_d   = GRANT1;
                bgrant1_d = 1'b1;
                bgrant2_d = 1'b0;
            end else begin
                state_d   = GRANT2;
                bgrant1_d = 1'b0;
                bgrant2_d = 1'b1;
            end
        end else begin
            last_d = last_d;
        end
    end

    // State and output registers; reset clears grants and split tracking at once.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            last_q       <= MST2;
            split_pend_q <= 1'b0;
            split_own_q  <= MST1;
            bgrant1_q    <= 1'b0;
            bgrant2_q    <= 1'b0;
            msel_q       <= 1'b0;
            msplit1_q    <= 1'b0;
            msplit2_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            split_pend_q <= split_pend_d;
            split_own_q  <= split_own_d;
            bgrant1_q    <= bgrant1_d;
            bgrant2_q    <= bgrant2_d;
            msel_q       <= msel_d;
            msplit1_q    <= msplit1_d;
            msplit2_q    <= msplit2_d;
        end
    end

    assign bgrant1  = bgrant1_q;
    assign bgrant2  = bgrant2_q;
    assign msel     = msel_q;
    assign msplit1  = msplit1_q;
    assign msplit2  = msplit2_q;
    assign bus_busy = bgrant1_q | bgrant2_q;

    bus_arbiter_chk u_chk (
        .clk     (clk),
        .rstn    (rstn),
        .bgrant1 (bgrant1_q),
        .bgrant2 (bgrant2_q),
        .msel    (msel_q),
        .msplit1 (msplit1_q),
        .msplit2 (msplit2_q)
    );

endmodule

// Structural invariants of the arbiter outputs.
module bus_arbiter_chk (
    input logic clk,
    input logic rstn,
    input logic bgrant1,
    input logic bgrant2,
    input logic msel,
    input logic msplit1,
    input logic msplit2
);

    a_grant_mutex: assert property (@(posedge clk) disable iff (!rstn)
        !(bgrant1 && bgrant2));

    a_msel_m1: assert property (@(posedge clk) disable iff (!rstn)
        bgrant1 |-> (msel == 1'b0));

    a_msel_m2: assert property (@(posedge clk) disable iff (!rstn)
        bgrant2 |-> (msel == 1'b1));

    a_one_split: assert property (@(posedge clk) disable iff (!rstn)
        !(msplit1 && msplit2));

endmodule
